// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the multicycle sequencer and the shared datapath.
// master: the sequencer (consumes IR/CPSR/ready, drives controls).
// slave:  the datapath side (drives IR/CPSR/ready, consumes controls).
interface multicycle_sequencer_if;
  logic [31:0] i_Instruction;
  logic [3:0]  i_CPSR;
  logic        i_Mem_Ready;

  logic        o_IR_Write;
  logic        o_PC_Write;
  logic        o_PC_Src;
  logic        o_Mem_Req;
  logic        o_Mem_Write_Enable;
  logic        o_Port3_Write_Enable;
  logic        o_Memory_to_Port3;
  logic        o_Flags_Write;
  logic [2:0]  o_ALU_OpCode;
  logic        o_Operand2_Src;
  logic [1:0]  o_Immediate_Src;
  logic [2:0]  o_State;
  logic        o_Fault;

  modport master (
    input  i_Instruction, i_CPSR, i_Mem_Ready,
    output o_IR_Write, o_PC_Write, o_PC_Src, o_Mem_Req, o_Mem_Write_Enable,
           o_Port3_Write_Enable, o_Memory_to_Port3, o_Flags_Write,
           o_ALU_OpCode, o_Operand2_Src, o_Immediate_Src, o_State, o_Fault
  );

  modport slave (
    output i_Instruction, i_CPSR, i_Mem_Ready,
    input  o_IR_Write, o_PC_Write, o_PC_Src, o_Mem_Req, o_Mem_Write_Enable,
           o_Port3_Write_Enable, o_Memory_to_Port3, o_Flags_Write,
           o_ALU_OpCode, o_Operand2_Src, o_Immediate_Src, o_State, o_Fault
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the ARMv7-subset core: sequences the shared
// register file, ALU and data-memory port through FETCH/DECODE/EXECUTE/
// MEM/WRITEBACK (plus BRANCH and a sticky FAULT).
// Optional feature: define MCS_TIMEOUT_EN to bound MEM waits; after
// TIMEOUT_CYCLES cycles without i_Mem_Ready the FSM faults. Without it MEM
// waits indefinitely.
// Controls are Moore decodes of the state register and the latched
// instruction, forced to 0 while reset is high.
module multicycle_sequencer
`ifdef MCS_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
  input  logic                          clk,
  input  logic                          reset,
  multicycle_sequencer_if.master        bus
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_BRANCH    = 3'd5,
    S_FAULT     = 3'd6
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  localparam logic [1:0] IMM_DP     = 2'b00;
  localparam logic [1:0] IMM_MEM    = 2'b01;
  localparam logic [1:0] IMM_BRANCH = 2'b10;

  state_e state_q;
  state_e state_d;

  // Instruction fields
  logic [3:0] cond;
  logic [1:0] op;
  logic       imm_bit;
  logic [3:0] cmd;
  logic       s_bit;
  logic [3:0] rd;

  assign cond    = bus.i_Instruction[31:28];
  assign op      = bus.i_Instruction[27:26];
  assign imm_bit = bus.i_Instruction[25];
  assign cmd     = bus.i_Instruction[24:21];
  assign s_bit   = bus.i_Instruction[20];
  assign rd      = bus.i_Instruction[15:12];

  // Operand fields belong to the datapath, not the sequencer
  logic unused_fields;
  assign unused_fields = ^{bus.i_Instruction[19:16], bus.i_Instruction[11:0]};

  logic is_mem;
  logic is_load;
  logic rd_is_pc;

  assign is_mem   = (op == 2'b01);
  assign is_load  = is_mem & s_bit;
  assign rd_is_pc = (rd == 4'hF);

  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = bus.i_CPSR;

  // ARM condition-code evaluation; 1111 is treated as never
  logic cond_pass;
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0:    cond_pass = flag_z;
      4'h1:    cond_pass = ~flag_z;
      4'h2:    cond_pass = flag_c;
      4'h3:    cond_pass = ~flag_c;
      4'h4:    cond_pass = flag_n;
      4'h5:    cond_pass = ~flag_n;
      4'h6:    cond_pass = flag_v;
      4'h7:    cond_pass = ~flag_v;
      4'h8:    cond_pass = flag_c & ~flag_z;
      4'h9:    cond_pass = ~flag_c | flag_z;
      4'hA:    cond_pass = (flag_n == flag_v);
      4'hB:    cond_pass = (flag_n != flag_v);
      4'hC:    cond_pass = ~flag_z & (flag_n == flag_v);
      4'hD:    cond_pass = flag_z | (flag_n != flag_v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Data-processing command decode; CMP reuses SUB and skips writeback
  logic       cmd_valid;
  logic       is_cmp;
  logic [2:0] dp_alu;
  always_comb begin
    cmd_valid = 1'b1;
    is_cmp    = 1'b0;
    dp_alu    = ALU_ADD;
    case (cmd)
      4'b0100: dp_alu = ALU_ADD;
      4'b0010: dp_alu = ALU_SUB;
      4'b0000: dp_alu = ALU_AND;
      4'b1100: dp_alu = ALU_ORR;
      4'b1010: begin
        dp_alu = ALU_SUB;
        is_cmp = 1'b1;
      end
      default: cmd_valid = 1'b0;
    endcase
  end

  logic mem_timeout;

`ifdef MCS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q;

  // Limit hit on the cycle that would be the TIMEOUT_CYCLES-th wait
  assign mem_timeout = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count consecutive MEM wait cycles; cleared whenever MEM is left
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if ((state_q == S_MEM) && (state_d == S_MEM)) begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end else begin
      wait_cnt_q <= '0;
    end
  end
`else
  assign mem_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (!cond_pass) begin
          state_d = S_FETCH;
        end else if (op == 2'b11) begin
          state_d = S_FAULT;
        end else if (op == 2'b10) begin
          state_d = S_BRANCH;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (is_mem) begin
          state_d = S_MEM;
        end else if (!cmd_valid) begin
          state_d = S_FAULT;
        end else if (is_cmp) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        if (bus.i_Mem_Ready) begin
          state_d = is_load ? S_WRITEBACK : S_FETCH;
        end else if (mem_timeout) begin
          state_d = S_FAULT;
        end
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_FAULT:     state_d = S_FAULT;
      default:     state_d = S_FAULT;
    endcase
  end

  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic       mem_req;
  logic       mem_we;
  logic       port3_we;
  logic       mem_to_port3;
  logic       flags_write;
  logic [2:0] alu_op;
  logic       op2_src;
  logic [1:0] imm_src;
  logic       fault;

  // Moore output decode, held at 0 while reset is asserted
  always_comb begin
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    port3_we     = 1'b0;
    mem_to_port3 = 1'b0;
    flags_write  = 1'b0;
    alu_op       = ALU_ADD;
    op2_src      = 1'b0;
    imm_src      = IMM_DP;
    fault        = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
        S_EXECUTE: begin
          if (is_mem) begin
            alu_op  = ALU_ADD;
            op2_src = 1'b1;
            imm_src = IMM_MEM;
          end else if (cmd_valid) begin
            alu_op      = dp_alu;
            op2_src     = imm_bit;
            imm_src     = IMM_DP;
            flags_write = s_bit | is_cmp;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = ~s_bit;
        end
        S_WRITEBACK: begin
          mem_to_port3 = is_mem;
          if (rd_is_pc) begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end else begin
            port3_we = 1'b1;
          end
        end
        S_BRANCH: begin
          alu_op   = ALU_ADD;
          op2_src  = 1'b1;
          imm_src  = IMM_BRANCH;
          pc_write = 1'b1;
          pc_src   = 1'b1;
        end
        S_FAULT: fault = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.o_IR_Write           = ir_write;
  assign bus.o_PC_Write           = pc_write;
  assign bus.o_PC_Src             = pc_src;
  assign bus.o_Mem_Req            = mem_req;
  assign bus.o_Mem_Write_Enable   = mem_we;
  assign bus.o_Port3_Write_Enable = port3_we;
  assign bus.o_Memory_to_Port3    = mem_to_port3;
  assign bus.o_Flags_Write        = flags_write;
  assign bus.o_ALU_OpCode         = alu_op;
  assign bus.o_Operand2_Src       = op2_src;
  assign bus.o_Immediate_Src      = imm_src;
  assign bus.o_State              = state_q;
  assign bus.o_Fault              = fault;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer. Outputs are packed into one
// 18-bit observation word:
// {IR_Write, PC_Write, PC_Src, Mem_Req, Mem_WE, P3_WE, Mem_to_P3, Flags_Write,
//  ALU[2:0], Op2_Src, Imm_Src[1:0], State[2:0], Fault}
// ALU/Op2/Imm bits are only compared in EXECUTE and BRANCH.
module tb_multicycle_sequencer;

  logic clk = 1'b0;
  logic reset;

  multicycle_sequencer_if bus();

  multicycle_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  localparam logic [17:0] V_FETCH  = 18'b1_1_0_0_0_0_0_0_000_0_00_000_0;
  localparam logic [17:0] V_DECODE = 18'b0_0_0_0_0_0_0_0_000_0_00_001_0;
  localparam logic [17:0] V_FAULT  = 18'b0_0_0_0_0_0_0_0_000_0_00_110_1;
  localparam logic [17:0] EX_ADDI  = 18'b0_0_0_0_0_0_0_0_000_1_00_010_0;
  localparam logic [17:0] EX_CMP   = 18'b0_0_0_0_0_0_0_1_001_1_00_010_0;
  localparam logic [17:0] EX_MEM   = 18'b0_0_0_0_0_0_0_0_000_1_01_010_0;
  localparam logic [17:0] WB_REG   = 18'b0_0_0_0_0_1_0_0_000_0_00_100_0;
  localparam logic [17:0] WB_PC    = 18'b0_1_1_0_0_0_0_0_000_0_00_100_0;
  localparam logic [17:0] WB_LD    = 18'b0_0_0_0_0_1_1_0_000_0_00_100_0;
  localparam logic [17:0] V_BRANCH = 18'b0_1_1_0_0_0_0_0_000_1_10_101_0;
  localparam logic [17:0] MEM_RD   = 18'b0_0_0_1_0_0_0_0_000_0_00_011_0;
  localparam logic [17:0] MEM_WR   = 18'b0_0_0_1_1_0_0_0_000_0_00_011_0;

  function automatic logic [17:0] outs();
    return {bus.o_IR_Write, bus.o_PC_Write, bus.o_PC_Src, bus.o_Mem_Req,
            bus.o_Mem_Write_Enable, bus.o_Port3_Write_Enable,
            bus.o_Memory_to_Port3, bus.o_Flags_Write, bus.o_ALU_OpCode,
            bus.o_Operand2_Src, bus.o_Immediate_Src, bus.o_State, bus.o_Fault};
  endfunction

  // Datapath-select bits are don't-care outside EXECUTE and BRANCH
  function automatic logic [17:0] care(input logic [17:0] e);
    if (e[3:1] == 3'd2 || e[3:1] == 3'd5) return '1;
    return 18'h3FC0F;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] obs;
    reset = 1'b1;
    bus.i_Instruction = 32'h0;
    bus.i_CPSR = 4'h0;
    bus.i_Mem_Ready = 1'b1;
    #3;
    obs = outs();
    checks++;
    if (obs !== 18'h0) begin
      fails++;
      $display("FAIL reset_hold: got %b expected %b", obs, 18'h0);
    end
    tick();
    obs = outs();
    checks++;
    if (obs !== 18'h0) begin
      fails++;
      $display("FAIL reset_over_edge: got %b expected %b", obs, 18'h0);
    end
    reset = 1'b0;
    #1;
    obs = outs();
    checks++;
    if ((obs & care(V_FETCH)) !== V_FETCH) begin
      fails++;
      $display("FAIL reset_release_fetch: got %b expected %b", obs, V_FETCH);
    end
  endtask

  task automatic test_add();
    logic [17:0] ev [4];
    logic [17:0] obs;
    ev = '{V_FETCH, V_DECODE, EX_ADDI, WB_REG};
    bus.i_Instruction = 32'hE2821005;
    bus.i_Mem_Ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      obs = outs();
      checks++;
      if ((obs & care(ev[i])) !== (ev[i] & care(ev[i]))) begin
        fails++;
        $display("FAIL add cycle %0d: got %b expected %b", i, obs, ev[i]);
      end
      tick();
    end
    checks++;
    if (bus.o_State !== 3'd0) begin
      fails++;
      $display("FAIL add_return: state %0d expected 0", bus.o_State);
    end
  endtask

  task automatic test_dp_variants();
    logic [31:0] ins [4];
    logic [17:0] ex [4];
    logic [17:0] wb [4];
    logic [17:0] ev [4];
    logic [17:0] obs;
    ins = '{32'hE1843005, 32'hE2543001, 32'hE2003001, 32'hE282F005};
    ex  = '{18'b0_0_0_0_0_0_0_0_011_0_00_010_0,
            18'b0_0_0_0_0_0_0_1_001_1_00_010_0,
            18'b0_0_0_0_0_0_0_0_010_1_00_010_0,
            EX_ADDI};
    wb  = '{WB_REG, WB_REG, WB_REG, WB_PC};
    for (int k = 0; k < 4; k++) begin
      ev = '{V_FETCH, V_DECODE, ex[k], wb[k]};
      bus.i_Instruction = ins[k];
      for (int i = 0; i < 4; i++) begin
        obs = outs();
        checks++;
        if ((obs & care(ev[i])) !== (ev[i] & care(ev[i]))) begin
          fails++;
          $display("FAIL dp_%0d cycle %0d: got %b expected %b", k, i, obs, ev[i]);
        end
        tick();
      end
    end
  endtask

  task automatic test_cond_codes();
    logic [3:0]  cpsr_tbl [3];
    logic [15:0] pass_tbl [3];
    logic [15:0] pt;
    logic [2:0]  exp_st;
    cpsr_tbl = '{4'b1010, 4'b0101, 4'b1001};
    pass_tbl = '{16'h6996, 16'h6A69, 16'h565A};
    for (int j = 0; j < 3; j++) begin
      pt = pass_tbl[j];
      bus.i_CPSR = cpsr_tbl[j];
      for (int c = 0; c < 16; c++) begin
        bus.i_Instruction = {4'(c), 28'h2821005};
        tick();
        tick();
        exp_st = pt[c] ? 3'd2 : 3'd0;
        checks++;
        if (bus.o_State !== exp_st) begin
          fails++;
          $display("FAIL cond cpsr=%b code=%0d: state %0d expected %0d",
                   cpsr_tbl[j], c, bus.o_State, exp_st);
        end
        if (pt[c]) begin
          tick();
          tick();
        end
      end
    end
    bus.i_CPSR = 4'h0;
  endtask

  task automatic test_cmp_branch();
    logic [17:0] ev [3];
    logic [17:0] obs;
    // CMP, flags then updated to Z=1, BEQ taken
    ev = '{V_FETCH, V_DECODE, EX_CMP};
    bus.i_CPSR = 4'b0000;
    bus.i_Instruction = 32'hE3510000;
    for (int i = 0; i < 3; i++) begin
      obs = outs();
      checks++;
      if ((obs & care(ev[i])) !== (ev[i] & care(ev[i]))) begin
        fails++;
        $display("FAIL cmp_z1 cycle %0d: got %b expected %b", i, obs, ev[i]);
      end
      tick();
    end
    bus.i_CPSR = 4'b0100;
    ev = '{V_FETCH, V_DECODE, V_BRANCH};
    bus.i_Instruction = 32'h0A000002;
    for (int i = 0; i < 3; i++) begin
      obs = outs();
      checks++;
      if ((obs & care(ev[i])) !== (ev[i] & care(ev[i]))) begin
        fails++;
        $display("FAIL beq_taken cycle %0d: got %b expected %b", i, obs, ev[i]);
      end
      tick();
    end
    checks++;
    if (bus.o_State !== 3'd0) begin
      fails++;
      $display("FAIL beq_taken_return: state %0d expected 0", bus.o_State);
    end
    // CMP, flags then Z=0, BEQ falls through after DECODE
    bus.i_Instruction = 32'hE3510000;
    tick();
    tick();
    tick();
    bus.i_CPSR = 4'b0000;
    bus.i_Instruction = 32'h0A000002;
    tick();
    tick();
    checks++;
    if (bus.o_State !== 3'd0) begin
      fails++;
      $display("FAIL beq_not_taken: state %0d expected 0", bus.o_State);
    end
  endtask

  task automatic test_load_wait();
    logic [17:0] ev [8];
    logic        rdy [8];
    logic [17:0] obs;
    ev  = '{V_FETCH, V_DECODE, EX_MEM, MEM_RD, MEM_RD, MEM_RD, MEM_RD, WB_LD};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bus.i_Instruction = 32'hE5910004;
    for (int i = 0; i < 8; i++) begin
      bus.i_Mem_Ready = rdy[i];
      obs = outs();
      checks++;
      if ((obs & care(ev[i])) !== (ev[i] & care(ev[i]))) begin
        fails++;
        $display("FAIL ldr_wait cycle %0d: got %b expected %b", i, obs, ev[i]);
      end
      tick();
    end
    checks++;
    if (bus.o_State !== 3'd0) begin
      fails++;
      $display("FAIL ldr_return: state %0d expected 0", bus.o_State);
    end
  endtask

  task automatic test_store();
    logic [17:0] ev [4];
    logic [17:0] obs;
    ev = '{V_FETCH, V_DECODE, EX_MEM, MEM_WR};
    bus.i_Instruction = 32'hE5810004;
    bus.i_Mem_Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      obs = outs();
      checks++;
      if ((obs & care(ev[i])) !== (ev[i] & care(ev[i]))) begin
        fails++;
        $display("FAIL str cycle %0d: got %b expected %b", i, obs, ev[i]);
      end
      tick();
    end
    checks++;
    if (bus.o_State !== 3'd0) begin
      fails++;
      $display("FAIL str_return: state %0d expected 0", bus.o_State);
    end
  endtask

  task automatic test_mem_wait_limit();
    int n;
    bus.i_Instruction = 32'hE5910004;
    bus.i_Mem_Ready = 1'b0;
`ifdef MCS_TIMEOUT_EN
    // Ready on the 16th MEM cycle still completes the load
    tick();
    tick();
    tick();
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (bus.o_State !== 3'd3) begin
      fails++;
      $display("FAIL timeout_still_mem: state %0d expected 3", bus.o_State);
    end
    bus.i_Mem_Ready = 1'b1;
    tick();
    checks++;
    if (bus.o_State !== 3'd4) begin
      fails++;
      $display("FAIL timeout_ready_wins: state %0d expected 4", bus.o_State);
    end
    tick();
    // Ready never arrives: fault after 16 MEM cycles
    bus.i_Mem_Ready = 1'b0;
    tick();
    tick();
    tick();
    n = 0;
    while (bus.o_State === 3'd3 && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 16 || bus.o_State !== 3'd6) begin
      fails++;
      $display("FAIL timeout_fault: mem cycles %0d state %0d expected 16 and 6",
               n, bus.o_State);
    end
    do_reset();
`else
    // Without the timeout MEM keeps waiting
    tick();
    tick();
    tick();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_State === 3'd3) n++;
      tick();
    end
    checks++;
    if (n !== 40 || bus.o_State !== 3'd3) begin
      fails++;
      $display("FAIL mem_wait_forever: mem cycles %0d state %0d expected 40 and 3",
               n, bus.o_State);
    end
    bus.i_Mem_Ready = 1'b1;
    tick();
    checks++;
    if (bus.o_State !== 3'd4) begin
      fails++;
      $display("FAIL mem_late_ready: state %0d expected 4", bus.o_State);
    end
    tick();
`endif
  endtask

  task automatic test_reset_mid_mem();
    logic [17:0] obs;
    bus.i_Instruction = 32'hE5910004;
    bus.i_Mem_Ready = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (bus.o_Mem_Req !== 1'b1) begin
      fails++;
      $display("FAIL mid_mem_req: got %b expected 1", bus.o_Mem_Req);
    end
    #2;
    reset = 1'b1;
    #1;
    obs = outs();
    checks++;
    if (obs !== 18'h0) begin
      fails++;
      $display("FAIL reset_mid_mem: got %b expected %b", obs, 18'h0);
    end
    tick();
    reset = 1'b0;
    #1;
    obs = outs();
    checks++;
    if ((obs & care(V_FETCH)) !== V_FETCH) begin
      fails++;
      $display("FAIL reset_mid_mem_release: got %b expected %b", obs, V_FETCH);
    end
  endtask

  task automatic test_undefined_cmd();
    logic [17:0] obs;
    bus.i_Instruction = 32'hE2200000;
    tick();
    tick();
    tick();
    obs = outs();
    checks++;
    if ((obs & care(V_FAULT)) !== V_FAULT) begin
      fails++;
      $display("FAIL undefined_cmd: got %b expected %b", obs, V_FAULT);
    end
    do_reset();
  endtask

  task automatic test_fault_sticky();
    logic [17:0] obs;
    bus.i_Instruction = 32'hEE000000;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      obs = outs();
      checks++;
      if ((obs & care(V_FAULT)) !== V_FAULT) begin
        fails++;
        $display("FAIL fault_sticky cycle %0d: got %b expected %b", i, obs, V_FAULT);
      end
      bus.i_Mem_Ready = ~bus.i_Mem_Ready;
      bus.i_Instruction = (i % 2 == 0) ? 32'hE2821005 : 32'hEE000000;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_dp_variants();
    test_cond_codes();
    test_cmp_branch();
    test_load_wait();
    test_store();
    test_mem_wait_limit();
    test_reset_mid_mem();
    test_undefined_cmd();
    test_fault_sticky();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
